// File: rtl/vector_fb_scheduler.sv
// Framebuffer write-port scheduler: sweeps the buffer (clear or fade) once per frame on the
// vblank rising edge, then hands the port to the vector line drawer until the next frame.
module vector_fb_scheduler #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  parameter int                    FADE_SHIFT  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vblank,
  input  logic                  pause,
  input  logic                  fade_mode,
  input  logic                  plot_valid,
  input  logic [ADDR_WIDTH-1:0] plot_addr,
  input  logic [DATA_WIDTH-1:0] plot_data,
  output logic                  plot_ready,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic                  fb_wren,
  output logic [DATA_WIDTH-1:0] fb_data,
  input  logic [DATA_WIDTH-1:0] fb_q,
  output logic                  frame_start,
  output logic                  clear_busy,
  output logic                  overrun,
  output logic [7:0]            frame_count
);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FADE_RD,
    FADE_WR,
    DRAW
  } state_t;

  state_t                state, state_nxt;
  logic                  vblank_q;
  logic                  vb_edge;
  logic                  start;
  logic [ADDR_WIDTH-1:0] sw_addr, sw_addr_nxt;
  logic [ADDR_WIDTH-1:0] addr_hold;

  // A paused frame ignores vblank entirely, so no frame starts and no overrun is flagged.
  assign vb_edge = vblank & ~vblank_q & ~pause;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sw_addr     <= '0;
      vblank_q    <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
      frame_start <= 1'b0;
      addr_hold   <= '0;
    end else begin
      state       <= state_nxt;
      sw_addr     <= sw_addr_nxt;
      vblank_q    <= vblank;
      frame_start <= start;
      addr_hold   <= fb_addr;
      if (start)
        frame_count <= frame_count + 8'd1;
      if (vb_edge && clear_busy)
        overrun <= 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    sw_addr_nxt = sw_addr;
    start       = 1'b0;
    clear_busy  = 1'b0;
    plot_ready  = 1'b0;
    fb_addr     = addr_hold;
    fb_wren     = 1'b0;
    fb_data     = '0;

    case (state)
      IDLE, DRAW: begin
        if (state == DRAW) begin
          plot_ready = ~pause;
          fb_addr    = plot_addr;
          fb_data    = plot_data;
          fb_wren    = plot_valid & ~pause;
        end
        // The fade/clear choice is captured by which sweep state is entered.
        if (vb_edge) begin
          start       = 1'b1;
          sw_addr_nxt = '0;
          state_nxt   = fade_mode ? FADE_RD : CLR;
        end
      end

      CLR: begin
        clear_busy  = 1'b1;
        fb_addr     = sw_addr;
        fb_wren     = 1'b1;
        fb_data     = CLEAR_VALUE;
        sw_addr_nxt = sw_addr + 1'b1;
        if (&sw_addr)
          state_nxt = DRAW;
      end

      FADE_RD: begin
        clear_busy = 1'b1;
        fb_addr    = sw_addr;
        state_nxt  = FADE_WR;
      end

      FADE_WR: begin
        // fb_q holds the pixel read at this same address in the previous cycle.
        clear_busy  = 1'b1;
        fb_addr     = sw_addr;
        fb_wren     = 1'b1;
        fb_data     = fb_q >> FADE_SHIFT;
        sw_addr_nxt = sw_addr + 1'b1;
        state_nxt   = (&sw_addr) ? DRAW : FADE_RD;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vector_fb_scheduler.sv
// Scoreboard bench for vector_fb_scheduler: a frame-level model predicts every framebuffer write,
// and a negedge monitor checks each write the DUT performs against the expected queue.
module tb_vector_fb_scheduler;

  localparam int             AW    = 8;
  localparam int             DW    = 8;
  localparam int             N     = 1 << AW;
  localparam logic [DW-1:0]  CLR_V = 8'h00;

  logic          clk        = 1'b0;
  logic          reset      = 1'b1;
  logic          vblank     = 1'b0;
  logic          pause      = 1'b0;
  logic          fade_mode  = 1'b0;
  logic          plot_valid = 1'b0;
  logic [AW-1:0] plot_addr  = '0;
  logic [DW-1:0] plot_data  = '0;
  logic          plot_ready;
  logic [AW-1:0] fb_addr;
  logic          fb_wren;
  logic [DW-1:0] fb_data;
  logic [DW-1:0] fb_q;
  logic          frame_start;
  logic          clear_busy;
  logic          overrun;
  logic [7:0]    frame_count;

  always #5 clk = ~clk;

  vector_fb_scheduler #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CLEAR_VALUE(CLR_V),
    .FADE_SHIFT (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vblank     (vblank),
    .pause      (pause),
    .fade_mode  (fade_mode),
    .plot_valid (plot_valid),
    .plot_addr  (plot_addr),
    .plot_data  (plot_data),
    .plot_ready (plot_ready),
    .fb_addr    (fb_addr),
    .fb_wren    (fb_wren),
    .fb_data    (fb_data),
    .fb_q       (fb_q),
    .frame_start(frame_start),
    .clear_busy (clear_busy),
    .overrun    (overrun),
    .frame_count(frame_count)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  logic [DW-1:0] fb_mem [N];
  logic [DW-1:0] ref_mem[N];

  int checks     = 0;
  int errors     = 0;
  int nstart     = 0;
  int busy_len   = 0;
  int busy_ready = 0;
  int exp_fc     = 0;
  int fc0, ns0, wait_n;
  logic [AW-1:0] pa;
  logic [DW-1:0] pd;
  bit            fade;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Framebuffer port model: registered read, write on the same edge.
  always @(posedge clk) begin
    if (fb_wren === 1'b1)
      fb_mem[fb_addr] <= fb_data;
    fb_q <= fb_mem[fb_addr];
  end

  // Monitor: pops one expected write per DUT write; tracks sweep length and frame starts.
  always @(negedge clk) begin
    if (frame_start === 1'b1) begin
      nstart++;
      busy_len = 0;
      check("start_addr", 32'(fb_addr), 32'd0);
      check("start_busy", 32'(clear_busy), 32'd1);
    end
    if (clear_busy === 1'b1) begin
      busy_len++;
      if (plot_ready !== 1'b0)
        busy_ready++;
    end
    if (fb_wren === 1'b1) begin
      check("write_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("write_addr", 32'(fb_addr), 32'(mon_e.addr));
        check("write_data", 32'(fb_data), 32'(mon_e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the whole sweep predicted from the reference image, then raise vblank.
  task automatic start_frame(input bit fd);
    wr_t w;
    tick();
    vblank = 1'b0;
    tick();
    for (int a = 0; a < N; a++) begin
      w.addr = AW'(a);
      w.data = fd ? (ref_mem[a] >> 1) : CLR_V;
      ref_mem[a] = w.data;
      exp_q.push_back(w);
    end
    fade_mode = fd;
    vblank    = 1'b1;
    exp_fc    = (exp_fc + 1) % 256;
  endtask

  // Returns on the negedge of the first cycle after the sweep.
  task automatic wait_sweep(input int exp_len);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (clear_busy !== 1'b1 && n < 8);
    check("sweep_began", 32'(clear_busy), 32'd1);
    n = 0;
    while (clear_busy === 1'b1 && n < 4 * N) begin
      @(negedge clk);
      n++;
    end
    check("sweep_ended", 32'(clear_busy), 32'd0);
    check("sweep_len", 32'(busy_len), 32'(exp_len));
  endtask

  task automatic send_plot(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit rnd_pause);
    wr_t w;
    int  n    = 0;
    bit  done = 1'b0;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
    ref_mem[a] = d;
    tick();
    plot_valid = 1'b1;
    plot_addr  = a;
    plot_data  = d;
    if (rnd_pause)
      pause = ($urandom_range(0, 3) == 0);
    while (!done && n < 64) begin
      @(negedge clk);
      n++;
      if (plot_ready === 1'b1)
        done = 1'b1;
      else begin
        tick();
        pause = rnd_pause && n < 32 && ($urandom_range(0, 3) == 0);
      end
    end
    check("plot_accepted", 32'(done), 32'd1);
    tick();
    plot_valid = 1'b0;
    pause      = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < N; a++) begin
      fb_mem[a]  = DW'($urandom);
      ref_mem[a] = fb_mem[a];
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_plot_ready", 32'(plot_ready), 32'd0);
    check("rst_fb_wren", 32'(fb_wren), 32'd0);
    check("rst_clear_busy", 32'(clear_busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    reset = 1'b0;

    // Clear sweep from IDLE
    start_frame(1'b0);
    wait_sweep(N);
    check("t1_plot_ready", 32'(plot_ready), 32'd1);
    check("t1_frame_count", 32'(frame_count), 32'(exp_fc));
    check("t1_nstart", 32'(nstart), 32'd1);
    repeat (8) send_plot(AW'($urandom), DW'($urandom), 1'b0);

    // Fade sweep with known pixels
    fb_mem[5]  = 8'hFF; ref_mem[5] = 8'hFF;
    fb_mem[6]  = 8'h01; ref_mem[6] = 8'h01;
    start_frame(1'b1);
    wait_sweep(2 * N);
    check("t2_mem5", 32'(fb_mem[5]), 32'h7F);
    check("t2_mem6", 32'(fb_mem[6]), 32'h00);
    check("t2_frame_count", 32'(frame_count), 32'(exp_fc));

    // Plot held through a clear sweep
    start_frame(1'b0);
    tick();
    pa = AW'(8'h34);
    pd = 8'hFF;
    mon_e.addr = pa;
    mon_e.data = pd;
    exp_q.push_back(mon_e);
    ref_mem[pa] = pd;
    plot_valid = 1'b1;
    plot_addr  = pa;
    plot_data  = pd;
    wait_sweep(N);
    check("t3_ready_in_sweep", 32'(busy_ready), 32'd0);
    check("t3_plot_ready", 32'(plot_ready), 32'd1);
    check("t3_fb_wren", 32'(fb_wren), 32'd1);
    check("t3_fb_addr", 32'(fb_addr), 32'(pa));
    tick();
    plot_valid = 1'b0;

    // Vblank edge mid fade sweep
    check("t4_overrun_pre", 32'(overrun), 32'd0);
    start_frame(1'b1);
    fc0 = exp_fc;
    ns0 = nstart;
    tick();
    vblank = 1'b0;
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (!(fb_wren === 1'b1 && fb_addr == AW'(N / 2)) && wait_n < 4 * N);
    check("t4_reached_mid", 32'(fb_addr), 32'(N / 2));
    tick();
    vblank = 1'b1;
    wait_sweep(2 * N);
    check("t4_overrun", 32'(overrun), 32'd1);
    check("t4_frame_count", 32'(frame_count), 32'(fc0));
    check("t4_nstart", 32'(nstart), 32'(ns0 + 1));

    // Pause in DRAW masks vblank and stalls the drawer
    ns0 = nstart;
    tick();
    vblank = 1'b0;
    tick();
    pa = AW'($urandom);
    pd = DW'($urandom);
    mon_e.addr = pa;
    mon_e.data = pd;
    exp_q.push_back(mon_e);
    ref_mem[pa] = pd;
    pause      = 1'b1;
    plot_valid = 1'b1;
    plot_addr  = pa;
    plot_data  = pd;
    vblank     = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("t5_plot_ready", 32'(plot_ready), 32'd0);
      check("t5_fb_wren", 32'(fb_wren), 32'd0);
      check("t5_frame_start", 32'(frame_start), 32'd0);
    end
    tick();
    pause = 1'b0;
    @(negedge clk);
    check("t5_resume_ready", 32'(plot_ready), 32'd1);
    check("t5_resume_wren", 32'(fb_wren), 32'd1);
    tick();
    plot_valid = 1'b0;
    check("t5_nstart", 32'(nstart), 32'(ns0));
    check("t5_frame_count", 32'(frame_count), 32'(exp_fc));

    // Randomised frames with plots and pause noise
    for (int f = 0; f < 4; f++) begin
      fade = 1'($urandom_range(0, 1));
      start_frame(fade);
      wait_sweep(fade ? 2 * N : N);
      check("rnd_frame_count", 32'(frame_count), 32'(exp_fc));
      repeat (6) send_plot(AW'($urandom), DW'($urandom), 1'b1);
    end

    // Reset in the middle of a clear sweep
    start_frame(1'b0);
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (!(fb_wren === 1'b1 && fb_addr == AW'(8'h10)) && wait_n < 4 * N);
    check("t6_reached_addr", 32'(fb_addr), 32'h10);
    reset  = 1'b1;
    vblank = 1'b0;
    @(posedge clk);
    #1;
    check("t6_fb_wren", 32'(fb_wren), 32'd0);
    check("t6_clear_busy", 32'(clear_busy), 32'd0);
    check("t6_overrun", 32'(overrun), 32'd0);
    check("t6_frame_count", 32'(frame_count), 32'd0);
    exp_q.delete();
    exp_fc = 0;
    tick();
    reset = 1'b0;
    start_frame(1'b0);
    wait_sweep(N);
    check("t6_restart_count", 32'(frame_count), 32'(exp_fc));
    send_plot(AW'($urandom), DW'($urandom), 1'b0);

    repeat (4) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_ready_in_sweep", 32'(busy_ready), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
